// File: rtl/shared_reg_arbiter_if.sv
// Bus between the processing stages (master) and the shared register arbiter (slave).
// ptr exposes the arbiter's round-robin pointer for observation.
interface shared_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int AW    = 3,
  parameter int PW    = (NREQ > 1) ? $clog2(NREQ) : 1
);
  logic                  hold;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       wr;
  logic [NREQ*AW-1:0]    addr;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      rdata;
  logic                  err;
  logic [PW-1:0]         ptr;

  modport master (
    output hold, req, wr, addr, wdata,
    input  gnt, rdata, err, ptr
  );

  modport slave (
    input  hold, req, wr, addr, wdata,
    output gnt, rdata, err, ptr
  );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter sharing one DEPTH x WIDTH register bank among NREQ requesters,
// one access per cycle, with registered one-hot grant, read data and error pulse.
module shared_reg_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input logic                clk,
  input logic                s_rst,
  shared_reg_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: req[i] is a valid that stays asserted with stable wr/addr/wdata until
  // gnt[i] pulses; gnt is the one-cycle acknowledge, and rdata/err are valid alongside it.
  logic [WIDTH-1:0] bank [DEPTH];
  logic [NREQ-1:0]  gnt_q;
  logic [WIDTH-1:0] rdata_q;
  logic             err_q;
  logic [PW-1:0]    ptr_q;

  logic [NREQ-1:0]  elig;
  logic [PW-1:0]    win;
  logic             found;
  logic [PW-1:0]    ptr_next;
  logic [AW-1:0]    win_addr;
  logic             win_wr;
  logic [WIDTH-1:0] win_wdata;
  logic             in_range;
  int               idx;

  // The requester granted last cycle is masked so nobody wins twice in a row.
  assign elig = bus.req & ~gnt_q;

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  assign ptr_next  = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);
  assign win_addr  = bus.addr[int'(win)*AW +: AW];
  assign win_wr    = bus.wr[win];
  assign win_wdata = bus.wdata[int'(win)*WIDTH +: WIDTH];
  assign in_range  = int'({1'b0, win_addr}) < DEPTH;

  always_ff @(posedge clk) begin
    if (s_rst) begin
      gnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else if (found && !bus.hold) begin
      gnt_q   <= NREQ'(1) << win;
      ptr_q   <= ptr_next;
      rdata_q <= '0;
      err_q   <= 1'b0;
      if (!in_range) begin
        err_q <= 1'b1;
      end else if (win_wr) begin
        bank[win_addr] <= win_wdata;
      end else begin
        rdata_q <= bank[win_addr];
      end
    end else begin
      gnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.rdata = rdata_q;
  assign bus.err   = err_q;
  assign bus.ptr   = ptr_q;
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter that shares one internal register bank (DEPTH words × WIDTH bits) between NREQ requesters.
- Each cycle it accepts at most one read or write access.
- It returns a registered one-hot grant and registered read data.
- It sits between the HLS-generated processing stages and the shared coefficient/result register storage in the coin-detection pipeline.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, data width of each bank word
- DEPTH, 8, number of bank words (need not be a power of two)
- AW, 3, address width; must satisfy 2^AW >= DEPTH

Ports:
- clk  input  1  single clock; all state updates on rising edge
- s_rst  input  1  synchronous reset, active-high
- hold  input  1  active-high; freezes arbitration
- req  input  NREQ  per-requester access request; bit i = requester i
- wr  input  NREQ  per-requester direction; 1 = write, 0 = read
- addr  input  NREQ*AW  packed addresses; requester i occupies bits [i*AW +: AW]
- wdata  input  NREQ*WIDTH  packed write data; requester i occupies bits [i*WIDTH +: WIDTH]
- gnt  output  NREQ  registered one-hot grant pulse
- rdata  output  WIDTH  registered read data; valid when gnt is high and the granted access was a read
- err  output  1  registered pulse; granted access had addr >= DEPTH

Behaviour:
- Reset (s_rst = 1 at a rising edge):
  - gnt = 0, rdata = 0, err = 0.
  - Priority pointer ptr = 0.
  - All bank words = 0.
  - s_rst dominates hold and all requests.
- Eligibility: requester i is eligible in cycle t when req[i] = 1 and gnt[i] = 0 in cycle t. The currently granted requester is therefore masked, and the same requester can never be granted on consecutive cycles.
- Selection: search eligible requesters in order ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. The first eligible one wins (index w).
- At the rising edge ending cycle t, if a winner exists and hold = 0:
  - gnt <= one-hot(w).
  - ptr <= (w+1) mod NREQ.
  - Write with addr < DEPTH: bank[addr] <= wdata of w; rdata <= 0.
  - Read with addr < DEPTH: rdata <= bank[addr] as it stood before this edge.
  - addr >= DEPTH: bank unchanged, rdata <= 0, err <= 1.
  - err <= 0 in every non-error case.
- At the same edge, if no winner exists or hold = 1:
  - gnt <= 0, rdata <= 0, err <= 0.
  - ptr unchanged, bank unchanged.
- Latency: request sampled in cycle t; gnt and rdata appear in cycle t+1.
- Handshake:
  - The requester holds req, wr, addr and wdata stable until it sees its gnt bit high.
  - In the gnt cycle it drops req, or raises it again for a new access.
  - If req is still high in the gnt cycle, that requester is masked for that cycle and becomes eligible again in cycle t+2. A held req therefore issues a repeat access every other cycle.
- Throughput: one access per cycle when different requesters alternate.
- Ordering: a write granted at edge E is visible to any read granted at edge E+1 or later.
- Requests are never queued internally. A requester not selected keeps req high and competes again in the next cycle.
- hold does not clear any pending state. Arbitration resumes in the first cycle with hold = 0, using the retained ptr.
- Invariants:
  - gnt has at most one bit set.
  - rdata = 0 and err = 0 whenever gnt = 0.

Test Plan:
- Reset, then requester 2 writes 0xA5 to addr 3 (req=0100, wr=0100) → gnt=0100 on the next cycle. Requester 0 then reads addr 3 → gnt=0001 with rdata=0xA5.
- All four requesters hold req high with reads from ptr=0 → grant sequence over successive cycles follows round-robin from ptr=0 with the held-req masking rule. Check: no requester is granted twice in a row, each requester is granted at least once in every 5-cycle window, and ptr advances to w+1 after each grant.
- Requester 1 writes 0x3C to addr 5 in cycle t, requester 3 reads addr 5 in cycle t+1 → read gnt in cycle t+2 with rdata=0x3C.
- DEPTH=6, requester 0 writes addr 7 with 0xFF → gnt=0001, err=1, rdata=0. A following read of every addr 0..5 returns 0.
- hold=1 for 3 cycles while req=1111 → gnt=0 throughout. After hold drops, the first grant goes to the requester at the retained ptr.
- Write 0x11 to addr 2, then assert s_rst for one cycle while req=0010 is active → next cycle gnt=0, ptr=0. A subsequent read of addr 2 returns 0x00.
